// File: rtl/pipeif_fetch.sv
// Instruction-fetch front end: PC register, instruction-memory request
// handshake, a one-entry fetch buffer and the IF/ID pipeline register.
// Delayed-branch architecture: the word after a branch always executes,
// so a redirect only steers the PC and never flushes IF/ID.
module pipeif_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wpcir,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] inst,
  output logic [31:0] dpc4,
  output logic        dvalid,
  output logic [31:0] pc
);

  // REQ: a fetch of pc is outstanding. FULL: the fetched word is parked in
  // the buffer because decode is stalled, and no request is issued.
  typedef enum logic [0:0] {
    ST_REQ  = 1'b0,
    ST_FULL = 1'b1
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [31:0] pc_r, pc_nxt_s;
  logic [31:0] inst_r, inst_nxt_s;
  logic [31:0] dpc4_r, dpc4_nxt_s;
  logic        dvalid_r, dvalid_nxt_s;
  logic [31:0] fbuf_inst_r, fbuf_inst_nxt_s;
  logic [31:0] fbuf_pc4_r, fbuf_pc4_nxt_s;
  logic        redirect_valid_r, redirect_valid_nxt_s;
  logic [31:0] redirect_pc_r, redirect_pc_nxt_s;

  logic        fetch_done_s;
  logic        accept_s;
  logic        taken_s;
  logic [31:0] target_s;
  logic [31:0] pc_plus4_s;
  logic [31:0] next_pc_s;

  assign fetch_done_s = (state_r == ST_REQ) & imem_ready;
  assign accept_s     = wpcir;
  assign taken_s      = dvalid_r & (pcsource != 2'b00);
  assign pc_plus4_s   = pc_r + 32'd4;

  // Select the redirect target from decode; targets are word aligned.
  always_comb begin
    target_s = 32'h0000_0000;
    case (pcsource)
      2'b01:   target_s = {bpc[31:2], 2'b00};
      2'b10:   target_s = {rpc[31:2], 2'b00};
      2'b11:   target_s = {jpc[31:2], 2'b00};
      default: target_s = 32'h0000_0000;
    endcase
  end

  // Pick the following fetch address: a live branch in ID wins, then a
  // redirect remembered while ID held bubbles, otherwise sequential.
  always_comb begin
    next_pc_s = pc_plus4_s;
    if (taken_s) begin
      next_pc_s = target_s;
    end else if (redirect_valid_r) begin
      next_pc_s = redirect_pc_r;
    end else begin
      next_pc_s = pc_plus4_s;
    end
  end

  // Next-state and datapath update for the fetch state machine.
  always_comb begin
    state_nxt_s          = state_r;
    pc_nxt_s             = pc_r;
    inst_nxt_s           = inst_r;
    dpc4_nxt_s           = dpc4_r;
    dvalid_nxt_s         = dvalid_r;
    fbuf_inst_nxt_s      = fbuf_inst_r;
    fbuf_pc4_nxt_s       = fbuf_pc4_r;
    redirect_valid_nxt_s = redirect_valid_r;
    redirect_pc_nxt_s    = redirect_pc_r;
    case (state_r)
      ST_REQ: begin
        if (fetch_done_s) begin
          if (accept_s) begin
            inst_nxt_s           = imem_rdata;
            dpc4_nxt_s           = pc_plus4_s;
            dvalid_nxt_s         = 1'b1;
            pc_nxt_s             = next_pc_s;
            redirect_valid_nxt_s = 1'b0;
          end else begin
            // Park the word; the branch in ID may still be unresolved, so
            // the PC is steered only when decode accepts it.
            fbuf_inst_nxt_s = imem_rdata;
            fbuf_pc4_nxt_s  = pc_plus4_s;
            state_nxt_s     = ST_FULL;
          end
        end else begin
          if (accept_s) begin
            inst_nxt_s   = NOP_INST;
            dvalid_nxt_s = 1'b0;
            if (taken_s) begin
              // The delay-slot fetch is still pending; remember where to go.
              redirect_valid_nxt_s = 1'b1;
              redirect_pc_nxt_s    = target_s;
            end else begin
              redirect_valid_nxt_s = redirect_valid_r;
            end
          end else begin
            state_nxt_s = ST_REQ;
          end
        end
      end
      ST_FULL: begin
        if (accept_s) begin
          inst_nxt_s           = fbuf_inst_r;
          dpc4_nxt_s           = fbuf_pc4_r;
          dvalid_nxt_s         = 1'b1;
          pc_nxt_s             = next_pc_s;
          redirect_valid_nxt_s = 1'b0;
          state_nxt_s          = ST_REQ;
        end else begin
          state_nxt_s = ST_FULL;
        end
      end
      default: begin
        state_nxt_s = ST_REQ;
      end
    endcase
  end

  // State and pipeline registers with synchronous reset; reset abandons any
  // outstanding request and ignores a completion in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r          <= ST_REQ;
      pc_r             <= RESET_PC;
      inst_r           <= NOP_INST;
      dpc4_r           <= 32'h0000_0000;
      dvalid_r         <= 1'b0;
      fbuf_inst_r      <= 32'h0000_0000;
      fbuf_pc4_r       <= 32'h0000_0000;
      redirect_valid_r <= 1'b0;
      redirect_pc_r    <= 32'h0000_0000;
    end else begin
      state_r          <= state_nxt_s;
      pc_r             <= pc_nxt_s;
      inst_r           <= inst_nxt_s;
      dpc4_r           <= dpc4_nxt_s;
      dvalid_r         <= dvalid_nxt_s;
      fbuf_inst_r      <= fbuf_inst_nxt_s;
      fbuf_pc4_r       <= fbuf_pc4_nxt_s;
      redirect_valid_r <= redirect_valid_nxt_s;
      redirect_pc_r    <= redirect_pc_nxt_s;
    end
  end

  assign imem_req  = (state_r == ST_REQ);
  assign imem_addr = pc_r;
  assign inst      = inst_r;
  assign dpc4      = dpc4_r;
  assign dvalid    = dvalid_r;
  assign pc        = pc_r;

endmodule

// File: tb/tb_pipeif_fetch.sv
// Bench for pipeif_fetch: a directed vector table walking the main fetch
// scenarios, followed by randomized traffic against a transaction-level
// reference model (fetch buffer and pending redirect kept as queues).
module tb_pipeif_fetch;

  logic        clock;
  logic        reset;
  logic        wpcir;
  logic [1:0]  pcsource;
  logic [31:0] bpc, rpc, jpc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] inst;
  logic [31:0] dpc4;
  logic        dvalid;
  logic [31:0] pc;

  int n_cmp = 0;
  int n_bad = 0;

  pipeif_fetch dut (
    .clock      (clock),
    .reset      (reset),
    .wpcir      (wpcir),
    .pcsource   (pcsource),
    .bpc        (bpc),
    .rpc        (rpc),
    .jpc        (jpc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .inst       (inst),
    .dpc4       (dpc4),
    .dvalid     (dvalid),
    .pc         (pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Distinct, address-dependent memory contents.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Memory answers combinationally with the word at the requested address.
  always_comb imem_rdata = memf(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        wp;
    logic [1:0]  ps;
    logic [31:0] bpc;
    logic [31:0] rpc;
    logic [31:0] jpc;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_nop;
    logic [31:0] e_iaddr;
    logic [31:0] e_dpc4;
    logic        e_dv;
  } vec_t;

  // Build a row; the selected target gets tgt, the others get junk values.
  function automatic vec_t mk(input logic rst, input logic wp, input logic [1:0] ps,
                              input logic [31:0] tgt, input logic rdy,
                              input logic e_req, input logic [31:0] e_addr,
                              input logic e_nop, input logic [31:0] e_iaddr,
                              input logic [31:0] e_dpc4, input logic e_dv);
    vec_t v;
    v.rst = rst; v.wp = wp; v.ps = ps; v.rdy = rdy;
    v.bpc = (ps == 2'b01) ? tgt : 32'h0000_BBB0;
    v.rpc = (ps == 2'b10) ? tgt : 32'h0000_CCC0;
    v.jpc = (ps == 2'b11) ? tgt : 32'h0000_DDD0;
    v.e_req = e_req; v.e_addr = e_addr; v.e_nop = e_nop;
    v.e_iaddr = e_iaddr; v.e_dpc4 = e_dpc4; v.e_dv = e_dv;
    return v;
  endfunction

  // Reference model state.
  typedef struct { logic [31:0] w; logic [31:0] p4; } fent_t;
  fent_t       fq[$];
  logic [31:0] rq[$];
  logic [31:0] m_pc, m_inst, m_dpc4;
  logic        m_dv;

  task automatic model_step(input logic rst, input logic wp, input logic [1:0] ps,
                            input logic [31:0] b, input logic [31:0] r,
                            input logic [31:0] j, input logic rdy);
    logic        tk;
    logic [31:0] tgt;
    fent_t       fe;
    tgt = (ps == 2'b01) ? b : (ps == 2'b10) ? r : j;
    tgt = tgt & 32'hFFFF_FFFC;
    tk  = m_dv && (ps != 2'b00);
    if (rst) begin
      m_pc = 32'h0000_0000; m_inst = 32'h0000_0000; m_dpc4 = 32'h0000_0000; m_dv = 1'b0;
      fq.delete(); rq.delete();
    end else if (!wp) begin
      if (fq.size() == 0 && rdy) fq.push_back('{memf(m_pc), m_pc + 32'd4});
    end else if (fq.size() != 0 || rdy) begin
      if (fq.size() != 0) fe = fq.pop_front();
      else fe = '{memf(m_pc), m_pc + 32'd4};
      m_inst = fe.w; m_dpc4 = fe.p4; m_dv = 1'b1;
      m_pc = tk ? tgt : (rq.size() != 0) ? rq[0] : m_pc + 32'd4;
      rq.delete();
    end else begin
      if (tk) begin
        rq.delete();
        rq.push_back(tgt);
      end
      m_inst = 32'h0000_0000; m_dv = 1'b0;
    end
  endtask

  vec_t vt[$];

  initial begin
    reset = 1'b1; wpcir = 1'b1; pcsource = 2'b00;
    bpc = 32'h0; rpc = 32'h0; jpc = 32'h0; imem_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    //          rst   wp    ps     tgt            rdy   req   addr           nop   iaddr          dpc4           dv
    vt.push_back(mk(1'b1, 1'b1, 2'b00, 32'h0,         1'b1, 1'b1, 32'h0000_0000, 1'b1, 32'h0,         32'h0000_0000, 1'b0));
    vt.push_back(mk(1'b0, 1'b1, 2'b00, 32'h0,         1'b1, 1'b1, 32'h0000_0004, 1'b0, 32'h0000_0000, 32'h0000_0004, 1'b1));
    vt.push_back(mk(1'b0, 1'b1, 2'b00, 32'h0,         1'b1, 1'b1, 32'h0000_0008, 1'b0, 32'h0000_0004, 32'h0000_0008, 1'b1));
    vt.push_back(mk(1'b0, 1'b1, 2'b00, 32'h0,         1'b0, 1'b1, 32'h0000_0008, 1'b1, 32'h0,         32'h0000_0008, 1'b0));
    vt.push_back(mk(1'b0, 1'b1, 2'b00, 32'h0,         1'b0, 1'b1, 32'h0000_0008, 1'b1, 32'h0,         32'h0000_0008, 1'b0));
    vt.push_back(mk(1'b0, 1'b1, 2'b00, 32'h0,         1'b1, 1'b1, 32'h0000_000C, 1'b0, 32'h0000_0008, 32'h0000_000C, 1'b1));
    vt.push_back(mk(1'b0, 1'b1, 2'b00, 32'h0,         1'b1, 1'b1, 32'h0000_0010, 1'b0, 32'h0000_000C, 32'h0000_0010, 1'b1));
    vt.push_back(mk(1'b0, 1'b0, 2'b00, 32'h0,         1'b1, 1'b0, 32'h0000_0010, 1'b0, 32'h0000_000C, 32'h0000_0010, 1'b1));
    vt.push_back(mk(1'b0, 1'b0, 2'b00, 32'h0,         1'b1, 1'b0, 32'h0000_0010, 1'b0, 32'h0000_000C, 32'h0000_0010, 1'b1));
    vt.push_back(mk(1'b0, 1'b0, 2'b00, 32'h0,         1'b1, 1'b0, 32'h0000_0010, 1'b0, 32'h0000_000C, 32'h0000_0010, 1'b1));
    vt.push_back(mk(1'b0, 1'b1, 2'b00, 32'h0,         1'b1, 1'b1, 32'h0000_0014, 1'b0, 32'h0000_0010, 32'h0000_0014, 1'b1));
    // branch with zero-wait delay slot (low target bits are ignored)
    vt.push_back(mk(1'b0, 1'b1, 2'b01, 32'h0000_0103, 1'b1, 1'b1, 32'h0000_0100, 1'b0, 32'h0000_0014, 32'h0000_0018, 1'b1));
    vt.push_back(mk(1'b0, 1'b1, 2'b00, 32'h0,         1'b1, 1'b1, 32'h0000_0104, 1'b0, 32'h0000_0100, 32'h0000_0104, 1'b1));
    // jump whose delay-slot fetch waits two cycles
    vt.push_back(mk(1'b0, 1'b1, 2'b11, 32'h0000_0200, 1'b0, 1'b1, 32'h0000_0104, 1'b1, 32'h0,         32'h0000_0104, 1'b0));
    vt.push_back(mk(1'b0, 1'b1, 2'b01, 32'h0000_0998, 1'b0, 1'b1, 32'h0000_0104, 1'b1, 32'h0,         32'h0000_0104, 1'b0));
    vt.push_back(mk(1'b0, 1'b1, 2'b00, 32'h0,         1'b1, 1'b1, 32'h0000_0200, 1'b0, 32'h0000_0104, 32'h0000_0108, 1'b1));
    vt.push_back(mk(1'b0, 1'b1, 2'b00, 32'h0,         1'b1, 1'b1, 32'h0000_0204, 1'b0, 32'h0000_0200, 32'h0000_0204, 1'b1));
    // jr taken in the cycle the buffered word is accepted
    vt.push_back(mk(1'b0, 1'b0, 2'b00, 32'h0,         1'b1, 1'b0, 32'h0000_0204, 1'b0, 32'h0000_0200, 32'h0000_0204, 1'b1));
    vt.push_back(mk(1'b0, 1'b1, 2'b10, 32'h0000_0302, 1'b1, 1'b1, 32'h0000_0300, 1'b0, 32'h0000_0204, 32'h0000_0208, 1'b1));
    vt.push_back(mk(1'b0, 1'b1, 2'b00, 32'h0,         1'b1, 1'b1, 32'h0000_0304, 1'b0, 32'h0000_0300, 32'h0000_0304, 1'b1));
    // stall without completion, then stall with completion
    vt.push_back(mk(1'b0, 1'b0, 2'b00, 32'h0,         1'b0, 1'b1, 32'h0000_0304, 1'b0, 32'h0000_0300, 32'h0000_0304, 1'b1));
    vt.push_back(mk(1'b0, 1'b0, 2'b00, 32'h0,         1'b1, 1'b0, 32'h0000_0304, 1'b0, 32'h0000_0300, 32'h0000_0304, 1'b1));
    vt.push_back(mk(1'b0, 1'b1, 2'b00, 32'h0,         1'b1, 1'b1, 32'h0000_0308, 1'b0, 32'h0000_0304, 32'h0000_0308, 1'b1));
    // pc+4 wraps at the top of the address space
    vt.push_back(mk(1'b0, 1'b1, 2'b11, 32'hFFFF_FFFC, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0000_0308, 32'h0000_030C, 1'b1));
    vt.push_back(mk(1'b0, 1'b1, 2'b00, 32'h0,         1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 1'b1));
    vt.push_back(mk(1'b0, 1'b1, 2'b00, 32'h0,         1'b1, 1'b1, 32'h0000_0004, 1'b0, 32'h0000_0000, 32'h0000_0004, 1'b1));
    // reset while the request to 0x40 is pending and ready pulses
    vt.push_back(mk(1'b0, 1'b1, 2'b11, 32'h0000_0040, 1'b1, 1'b1, 32'h0000_0040, 1'b0, 32'h0000_0004, 32'h0000_0008, 1'b1));
    vt.push_back(mk(1'b0, 1'b1, 2'b00, 32'h0,         1'b0, 1'b1, 32'h0000_0040, 1'b1, 32'h0,         32'h0000_0008, 1'b0));
    vt.push_back(mk(1'b1, 1'b1, 2'b00, 32'h0,         1'b1, 1'b1, 32'h0000_0000, 1'b1, 32'h0,         32'h0000_0000, 1'b0));
    vt.push_back(mk(1'b0, 1'b1, 2'b00, 32'h0,         1'b1, 1'b1, 32'h0000_0004, 1'b0, 32'h0000_0000, 32'h0000_0004, 1'b1));

    for (int i = 0; i < vt.size(); i++) begin
      reset = vt[i].rst; wpcir = vt[i].wp; pcsource = vt[i].ps;
      bpc = vt[i].bpc; rpc = vt[i].rpc; jpc = vt[i].jpc; imem_ready = vt[i].rdy;
      @(posedge clock);
      #1;
      check($sformatf("vec%0d.imem_req", i),  {31'd0, imem_req}, {31'd0, vt[i].e_req});
      check($sformatf("vec%0d.imem_addr", i), imem_addr, vt[i].e_addr);
      check($sformatf("vec%0d.pc", i),        pc, vt[i].e_addr);
      check($sformatf("vec%0d.inst", i),      inst, vt[i].e_nop ? 32'h0000_0000 : memf(vt[i].e_iaddr));
      check($sformatf("vec%0d.dpc4", i),      dpc4, vt[i].e_dpc4);
      check($sformatf("vec%0d.dvalid", i),    {31'd0, dvalid}, {31'd0, vt[i].e_dv});
    end

    // Randomized traffic against the reference model.
    model_step(1'b1, 1'b1, 2'b00, 32'h0, 32'h0, 32'h0, 1'b1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    for (int c = 0; c < 3000; c++) begin
      reset      = ($urandom_range(0, 199) == 0);
      wpcir      = ($urandom_range(0, 3) != 0);
      imem_ready = ($urandom_range(0, 2) != 0);
      pcsource   = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      bpc        = $urandom;
      rpc        = $urandom;
      jpc        = $urandom;
      model_step(reset, wpcir, pcsource, bpc, rpc, jpc, imem_ready);
      @(posedge clock);
      #1;
      check("rnd.imem_req",  {31'd0, imem_req}, {31'd0, (fq.size() == 0)});
      check("rnd.imem_addr", imem_addr, m_pc);
      check("rnd.inst",      inst, m_inst);
      check("rnd.dpc4",      dpc4, m_dpc4);
      check("rnd.dvalid",    {31'd0, dvalid}, {31'd0, m_dv});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeif_fetch.md
Name: pipeif_fetch

Overview:
- Instruction-fetch front end of the 5-stage pipeline.
- Owns the PC register, the instruction-memory request handshake, a one-entry fetch buffer, and the IF/ID pipeline register.
- Supplies inst/dpc4 to the decode stage and consumes the decode stage's redirect outputs (pcsource, bpc, jpc, register target) and its wpcir stall.
- The architecture is delayed-branch: the instruction after a branch or jump always executes, so there is no flush.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- NOP_INST, 32'h00000000, word injected into IF/ID as a bubble (sll $0,$0,0).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- wpcir  in  1  from ID; 1 = IF/ID and PC may advance, 0 = decode stall (hold).
- pcsource  in  2  from ID; 00 = pc+4, 01 = bpc, 10 = rpc, 11 = jpc.
- bpc  in  32  branch target from ID.
- rpc  in  32  jr target (forwarded rs) from ID.
- jpc  in  32  jump target from ID.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; equals pc while imem_req=1.
- imem_rdata  in  32  fetched word; valid when imem_req & imem_ready.
- imem_ready  in  1  memory completion strobe; ignored when imem_req=0.
- inst  out  32  IF/ID instruction.
- dpc4  out  32  IF/ID pc+4 of inst.
- dvalid  out  1  IF/ID holds a real instruction (0 = bubble).
- pc  out  32  current fetch PC (debug).

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: pc=RESET_PC, inst=NOP_INST, dpc4=0, dvalid=0, fbuf empty, redirect_valid=0, state=REQ. imem_req=1 from the first cycle after reset deasserts.
- Reset mid-request: any outstanding request is abandoned; an imem_ready in the reset cycle is ignored.
- States:
  - REQ: imem_req=1, imem_addr=pc.
  - FULL: imem_req=0; fbuf holds {word, pc+4}.
- Definitions:
  - fetch_done = state==REQ & imem_ready.
  - accept = wpcir.
  - taken = dvalid & pcsource!=00.
  - target = mux(pcsource): bpc, rpc or jpc, with [1:0] forced to 00.
  - next_pc = taken ? target : redirect_valid ? redirect_pc : pc+4.
- REQ, fetch_done & accept:
  - IF/ID <= {imem_rdata, pc+4, 1}.
  - pc <= next_pc; clear redirect_valid; stay REQ.
- REQ, fetch_done & !accept:
  - fbuf <= {imem_rdata, pc+4}; go FULL.
  - pc, IF/ID and redirect unchanged. The branch in ID may not be resolved yet.
- REQ, !fetch_done & accept:
  - IF/ID <= {NOP_INST, dpc4 unchanged, 0}; pc unchanged.
  - If taken: redirect_valid <= 1, redirect_pc <= target.
- REQ, !fetch_done & !accept: hold everything.
- FULL & accept:
  - IF/ID <= {fbuf, 1}.
  - pc <= next_pc, using the ID outputs of this cycle; clear redirect_valid; go REQ.
- FULL & !accept: hold.
- Invariants:
  - taken and redirect_valid are never both 1. A redirect exists only while ID holds a bubble.
  - pcsource, bpc, rpc and jpc are sampled only when accept=1.
  - imem_addr stays stable while imem_req=1 and not ready.
  - pc+4 wraps modulo 2^32.
- Latency: with zero-wait memory, one instruction per cycle. An instruction appears in IF/ID one cycle after its fetch completes. A taken branch in ID redirects the fetch issued in the next cycle (delay slot = word fetched in the branch's ID cycle).

Test Plan:
- Zero-wait memory, imem_ready tied 1, wpcir=1, RESET_PC=0 -> imem_addr 0,4,8,12 on consecutive cycles. inst/dpc4 follow one cycle later: dpc4=4,8,12; dvalid=1 from cycle 2.
- imem_ready low for 2 cycles on addr 8 -> two bubbles (inst=0, dvalid=0, dpc4 held at 8). imem_addr held at 8; then inst=word@8, dpc4=12.
- wpcir=0 for 3 cycles while the fetch of addr 16 completes in the first -> state FULL, imem_req=0, IF/ID unchanged. The cycle wpcir returns to 1: inst=word@16, dpc4=20, imem_addr=20 next cycle.
- Branch in ID at dpc4=12 with pcsource=01, bpc=0x100, zero-wait -> delay slot @12 enters IF/ID; next imem_addr=0x100.
- Same branch but the delay-slot fetch @12 waits 2 cycles -> redirect_pc=0x100 latched; bubbles in IF/ID. After word@12 arrives, imem_addr=0x100 (not 16).
- Assert reset while a request to 0x40 is pending and imem_ready pulses in the reset cycle -> pc=RESET_PC, dvalid=0, inst=0. The word is discarded; the next request is to RESET_PC.
